// File: rtl/imm_pkg.sv
// Shared immediate-format selectors and base opcodes for the decode stage.
// Control uses immSelFromInst to derive the selector fed to imm_gen_pipe.
package imm_pkg;

    localparam logic [2:0] IMM_NONE  = 3'd0;
    localparam logic [2:0] IMM_I     = 3'd1;
    localparam logic [2:0] IMM_B     = 3'd2;
    localparam logic [2:0] IMM_S     = 3'd3;
    localparam logic [2:0] IMM_U     = 3'd4;
    localparam logic [2:0] IMM_J     = 3'd5;
    localparam logic [2:0] IMM_SHAMT = 3'd6;
    localparam logic [2:0] IMM_ZIMM  = 3'd7;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Shift-immediates (funct3 001/101) carry a shamt rather than a signed I immediate.
    function automatic logic [2:0] immSelFromInst(input logic [31:0] inst);
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [2:0] sel;
        opcode = inst[6:0];
        funct3 = inst[14:12];
        sel    = IMM_NONE;
        case (opcode)
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    sel = IMM_SHAMT;
                end else begin
                    sel = IMM_I;
                end
            end
            OPC_LOAD, OPC_JALR: sel = IMM_I;
            OPC_STORE:          sel = IMM_S;
            OPC_BRANCH:         sel = IMM_B;
            OPC_LUI, OPC_AUIPC: sel = IMM_U;
            OPC_JAL:            sel = IMM_J;
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    sel = IMM_ZIMM;
                end
            end
            default:            sel = IMM_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/imm_gen_core.sv
// Combinational immediate extraction for every RV32/RV64 base format.
// Shared with the execute-stage branch unit, so it holds no state.
module imm_gen_core
    import imm_pkg::*;
#(
    parameter int DATA_LENGTH = 32
) (
    input  logic [31:0]            inst,
    input  logic [2:0]             sel,
    output logic [DATA_LENGTH-1:0] imm
);

    // RV64 shifts use a 6-bit shamt; RV32 only 5.
    localparam int SHAMT_W = (DATA_LENGTH == 64) ? 6 : 5;

    logic unusedOpcode;
    assign unusedOpcode = ^inst[6:0];

    // Size-casting a signed value sign-extends to the output width.
    always_comb begin
        imm = '0;
        case (sel)
            IMM_NONE:  imm = '0;
            IMM_I:     imm = DATA_LENGTH'($signed(inst[31:20]));
            IMM_B:     imm = DATA_LENGTH'($signed({inst[31], inst[7], inst[30:25],
                                                   inst[11:8], 1'b0}));
            IMM_S:     imm = DATA_LENGTH'($signed({inst[31:25], inst[11:7]}));
            IMM_U:     imm = DATA_LENGTH'($signed({inst[31:12], 12'b0}));
            IMM_J:     imm = DATA_LENGTH'($signed({inst[31], inst[19:12], inst[20],
                                                   inst[30:21], 1'b0}));
            IMM_SHAMT: imm = DATA_LENGTH'(inst[20 +: SHAMT_W]);
            IMM_ZIMM:  imm = DATA_LENGTH'(inst[19:15]);
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: computes the immediate combinationally and
// registers it behind a 2-entry skid buffer so in_ready comes straight from a flop.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int DATA_LENGTH = 32,
    parameter int INST_LENGTH = 32,
    parameter int TAG_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INST_LENGTH-1:0] in_inst,
    input  logic [2:0]             in_sel,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_LENGTH-1:0] out_imm,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    logic [DATA_LENGTH-1:0] genImm;
    logic                   mainValid;
    logic [DATA_LENGTH-1:0] mainImm;
    logic [TAG_WIDTH-1:0]   mainTag;
    logic                   skidValid;
    logic                   skidEmpty;
    logic [DATA_LENGTH-1:0] skidImm;
    logic [TAG_WIDTH-1:0]   skidTag;
    logic                   accept;
    logic                   consume;

    imm_gen_core #(
        .DATA_LENGTH(DATA_LENGTH)
    ) core (
        .inst(in_inst[31:0]),
        .sel (in_sel),
        .imm (genImm)
    );

    assign accept    = in_valid && skidEmpty;
    assign consume   = mainValid && out_ready;
    assign in_ready  = skidEmpty;
    assign out_valid = mainValid;
    assign out_imm   = mainImm;
    assign out_tag   = mainTag;

    // skidEmpty is kept as its own flop, always the complement of skidValid.
    always_ff @(posedge clk) begin
        if (rst) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            skidEmpty <= 1'b1;
            mainImm   <= '0;
            mainTag   <= '0;
        end else if (flush) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            skidEmpty <= 1'b1;
        end else if (!mainValid || consume) begin
            if (skidValid) begin
                mainValid <= 1'b1;
                mainImm   <= skidImm;
                mainTag   <= skidTag;
                skidValid <= 1'b0;
                skidEmpty <= 1'b1;
            end else begin
                mainValid <= accept;
                if (accept) begin
                    mainImm <= genImm;
                    mainTag <= in_tag;
                end
            end
        end else if (accept) begin
            skidValid <= 1'b1;
            skidEmpty <= 1'b0;
            skidImm   <= genImm;
            skidTag   <= in_tag;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 32-bit and a 64-bit instance driven in lockstep.
// Directed format vectors, backpressure, flush, reset and a random stream.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        inValid;
    logic        outReady;
    logic [31:0] inInst;
    logic [2:0]  inSel;
    logic [31:0] inTag;
    logic        inReady32, outValid32, inReady64, outValid64;
    logic [31:0] outImm32, outTag32, outTag64;
    logic [63:0] outImm64;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic [31:0] tag;
    } sbEntry_t;

    sbEntry_t scoreboard[$];
    sbEntry_t popped;
    sbEntry_t pushed;

    always #5 clock = ~clock;

    imm_gen_pipe #(.DATA_LENGTH(32), .INST_LENGTH(32), .TAG_WIDTH(32)) dut32 (
        .clk(clock), .rst(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady32), .in_inst(inInst), .in_sel(inSel), .in_tag(inTag),
        .out_valid(outValid32), .out_ready(outReady), .out_imm(outImm32), .out_tag(outTag32)
    );

    imm_gen_pipe #(.DATA_LENGTH(64), .INST_LENGTH(32), .TAG_WIDTH(32)) dut64 (
        .clk(clock), .rst(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady64), .in_inst(inInst), .in_sel(inSel), .in_tag(inTag),
        .out_valid(outValid64), .out_ready(outReady), .out_imm(outImm64), .out_tag(outTag64)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference immediate, written straight from the format table.
    function automatic logic [63:0] refImm(input logic [31:0] i, input logic [2:0] sel, input bit wide);
        logic [63:0] r;
        case (sel)
            3'd1:    r = {{52{i[31]}}, i[31:20]};
            3'd2:    r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    r = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd4:    r = {{32{i[31]}}, i[31:12], 12'h000};
            3'd5:    r = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd6:    r = wide ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
            3'd7:    r = {59'd0, i[19:15]};
            default: r = 64'd0;
        endcase
        if (!wide) r = {32'd0, r[31:0]};
        return r;
    endfunction

    // Monitor: pop on consume, push on accept; reset and flush discard everything pending.
    always @(negedge clock) begin
        if (reset || flush) begin
            scoreboard.delete();
        end else begin
            if (outValid32 && outReady) begin
                if (scoreboard.size() == 0) begin
                    checkOutput("sbUnderflow", 64'd1, 64'd0);
                end else begin
                    popped = scoreboard.pop_front();
                    checkOutput("sbImm32", {32'd0, outImm32}, popped.imm32);
                    checkOutput("sbImm64", outImm64, popped.imm64);
                    checkOutput("sbTag32", {32'd0, outTag32}, {32'd0, popped.tag});
                    checkOutput("sbTag64", {32'd0, outTag64}, {32'd0, popped.tag});
                    checkOutput("sbValid64", {63'd0, outValid64}, 64'd1);
                end
            end
            if (inValid && inReady32) begin
                pushed.imm32 = refImm(inInst, inSel, 1'b0);
                pushed.imm64 = refImm(inInst, inSel, 1'b1);
                pushed.tag   = inTag;
                scoreboard.push_back(pushed);
            end
        end
    end

    // Present one instruction with out_ready high and check it appears exactly one cycle later.
    task automatic applyStimulus(input logic [31:0] inst, input logic [2:0] sel, input logic [31:0] tag,
                                 input logic [63:0] exp32, input logic [63:0] exp64);
        int waitCycles = 0;
        inValid = 1'b1;
        inInst  = inst;
        inSel   = sel;
        inTag   = tag;
        @(negedge clock);
        while (!inReady32 && waitCycles < 20) begin
            @(negedge clock);
            waitCycles++;
        end
        if (!inReady32) checkOutput("readyTimeout", 64'd0, 64'd1);
        @(posedge clock);
        #1;
        inValid = 1'b0;
        @(negedge clock);
        checkOutput("latencyValid", {63'd0, outValid32}, 64'd1);
        checkOutput("imm32", {32'd0, outImm32}, exp32);
        checkOutput("imm64", outImm64, exp64);
        checkOutput("tag", {32'd0, outTag32}, {32'd0, tag});
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int nextTag;
        bit accepted;
        reset = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        inInst = '0; inSel = '0; inTag = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkOutput("rstValid", {63'd0, outValid32}, 64'd0);
        checkOutput("rstReady", {63'd0, inReady32}, 64'd1);
        checkOutput("rstImm32", {32'd0, outImm32}, 64'd0);
        checkOutput("rstImm64", outImm64, 64'd0);
        checkOutput("rstTag", {32'd0, outTag32}, 64'd0);

        // Directed format vectors.
        applyStimulus(32'hFFF00093, IMM_I,     32'h11, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        applyStimulus(32'hFE112E23, IMM_S,     32'h12, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
        applyStimulus(32'hFFDFF06F, IMM_J,     32'h13, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
        applyStimulus(32'h00000863, IMM_B,     32'h14, 64'h10, 64'h10);
        applyStimulus(32'h123450B7, IMM_U,     32'h15, 64'h12345000, 64'h12345000);
        applyStimulus(32'h800000B7, IMM_U,     32'h16, 64'h80000000, 64'hFFFFFFFF80000000);
        applyStimulus(32'h03F09093, IMM_SHAMT, 32'h17, 64'h1F, 64'h3F);
        applyStimulus(32'h3400D073, IMM_ZIMM,  32'h18, 64'h1, 64'h1);
        applyStimulus(32'hFFFFFFFF, IMM_NONE,  32'h19, 64'h0, 64'h0);
        stepCycle();

        // Backpressure: tags 1..6 streamed, consumer stalls in cycles 2-4.
        nextTag = 1;
        for (int c = 1; c <= 11; c++) begin
            inValid  = (nextTag <= 6);
            inTag    = nextTag;
            inInst   = {12'(nextTag * 3), 20'h00093};
            inSel    = IMM_I;
            outReady = !(c >= 2 && c <= 4);
            @(negedge clock);
            accepted = inValid && inReady32;
            if (c == 3) begin
                checkOutput("bpReadyLow", {63'd0, inReady32}, 64'd0);
                checkOutput("bpHoldValid", {63'd0, outValid32}, 64'd1);
            end
            if (c == 3 || c == 4) begin
                checkOutput("bpHoldTag", {32'd0, outTag32}, 64'd1);
                checkOutput("bpHoldImm", {32'd0, outImm32}, 64'd3);
            end
            if (c >= 5 && c <= 10) begin
                checkOutput("bpNoGap", {63'd0, outValid32}, 64'd1);
                checkOutput("bpOrder", {32'd0, outTag32}, 64'(c - 4));
            end
            stepCycle();
            if (accepted) nextTag++;
        end
        inValid = 1'b0; outReady = 1'b1;
        stepCycle();

        // Flush with main and skid both full and an input offered.
        outReady = 1'b0; inValid = 1'b1; inSel = IMM_I;
        inTag = 32'd21; inInst = 32'h01500093; stepCycle();
        inTag = 32'd22; inInst = 32'h01600093; stepCycle();
        inTag = 32'd23; inInst = 32'h01700093; flush = 1'b1;
        @(negedge clock);
        checkOutput("flushPreFull", {63'd0, inReady32}, 64'd0);
        stepCycle();
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        @(negedge clock);
        checkOutput("flushValid", {63'd0, outValid32}, 64'd0);
        checkOutput("flushReady", {63'd0, inReady32}, 64'd1);
        repeat (3) begin
            stepCycle();
            @(negedge clock);
            checkOutput("flushNoLeak", {63'd0, outValid32}, 64'd0);
        end

        // Flush with only main full: the offered input has in_ready=1 but must still be dropped.
        outReady = 1'b0; inValid = 1'b1;
        inTag = 32'd31; inInst = 32'h01F00093; stepCycle();
        inTag = 32'd32; inInst = 32'h02000093; flush = 1'b1;
        @(negedge clock);
        checkOutput("flush2PreReady", {63'd0, inReady32}, 64'd1);
        stepCycle();
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checkOutput("flush2Drop", {63'd0, outValid32}, 64'd0);
            stepCycle();
        end

        // Reset mid-stream with both entries full.
        outReady = 1'b0; inValid = 1'b1;
        inTag = 32'd41; inInst = 32'hABC00093; stepCycle();
        inTag = 32'd42; inInst = 32'h12300093; stepCycle();
        inValid = 1'b0; reset = 1'b1;
        stepCycle();
        reset = 1'b0; outReady = 1'b1;
        @(negedge clock);
        checkOutput("midRstValid", {63'd0, outValid32}, 64'd0);
        checkOutput("midRstImm32", {32'd0, outImm32}, 64'd0);
        checkOutput("midRstImm64", outImm64, 64'd0);
        checkOutput("midRstTag", {32'd0, outTag32}, 64'd0);
        checkOutput("midRstReady", {63'd0, inReady32}, 64'd1);
        applyStimulus(32'h00000863, IMM_B, 32'd43, 64'h10, 64'h10);
        stepCycle();

        // Random traffic with random backpressure, checked by the scoreboard.
        for (int c = 0; c < 400; c++) begin
            inValid  = ($urandom_range(0, 1) == 1);
            inInst   = $urandom;
            inSel    = 3'($urandom_range(0, 7));
            inTag    = $urandom;
            outReady = ($urandom_range(0, 3) != 0);
            stepCycle();
        end
        inValid = 1'b0; outReady = 1'b1;
        repeat (5) stepCycle();
        checkOutput("sbDrained", 64'(scoreboard.size()), 64'd0);
        checkOutput("drainedValid", {63'd0, outValid32}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage.
- Takes a full instruction word, a format selector and a sideband tag, and produces the sign- or zero-extended immediate one cycle later.
- Supports every RV32/RV64 base format plus shamt and CSR zimm.
- Valid/ready handshakes on both sides, a 2-entry skid buffer so in_ready is registered, and a synchronous flush for branch redirect.

Parameters:
- DATA_LENGTH, 32, immediate output width; legal values 32 or 64.
- INST_LENGTH, 32, instruction width; fixed at 32.
- TAG_WIDTH, 32, width of the sideband tag (PC or rd index) carried alongside the instruction.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drops all buffered entries.
- in_valid  input  1  instruction presented.
- in_ready  output  1  block can accept; registered.
- in_inst  input  INST_LENGTH  full instruction word.
- in_sel  input  3  format select.
- in_tag  input  TAG_WIDTH  sideband, passed through unchanged.
- out_valid  output  1  immediate valid.
- out_ready  input  1  consumer accepts.
- out_imm  output  DATA_LENGTH  generated immediate.
- out_tag  output  TAG_WIDTH  tag matching out_imm.

Behaviour:
- Format select (sext = sign-extend to DATA_LENGTH, zext = zero-extend), with i = in_inst:
  - 000 NONE: 0.
  - 001 I: sext(i[31:20]).
  - 010 B: sext({i[31],i[7],i[30:25],i[11:8],0}).
  - 011 S: sext({i[31:25],i[11:7]}).
  - 100 U: sext({i[31:12],12'b0}).
  - 101 J: sext({i[31],i[19:12],i[20],i[30:21],0}).
  - 110 SHAMT: zext(i[24:20]) when DATA_LENGTH=32, zext(i[25:20]) when 64.
  - 111 ZIMM: zext(i[19:15]).
- Generation is combinational on the input side. The main register stores the computed immediate and tag, not the raw instruction.
- Latency: exactly 1 cycle from accepted input to out_valid when the output is idle.
- Accept rule: an input is accepted when in_valid && in_ready. The output is consumed when out_valid && out_ready.
- State: main {valid, imm, tag} drives the outputs; skid {valid, imm, tag} holds overflow.
  - in_ready = !skid_valid, taken directly from a flop.
- Update rules per cycle, in priority order:
  1. rst: main_valid = skid_valid = 0; out_imm = 0; out_tag = 0. in_ready reads 1 in the first cycle after reset.
  2. flush: main_valid = skid_valid = 0. Any input offered in the same cycle is dropped; the producer must not count it as accepted. Data registers keep their values.
  3. Main empty or consumed this cycle:
     - Main loads from skid if skid is valid, else from the accepted input.
     - If skid is valid and an input is accepted, that case cannot occur, because in_ready=0.
     - Skid clears when it is moved into main.
  4. Main full and not consumed, with an input accepted: the input goes to skid and skid_valid = 1.
- Ordering is strictly FIFO.
- Capacity is 2 entries; no entry is lost or duplicated under any out_ready pattern.
- Output stability: while out_valid && !out_ready, out_imm and out_tag must hold steady.
- Simultaneous accept and consume with skid empty: main is replaced in the same edge, giving full throughput of 1 per cycle.
- Reset or flush mid-stream: all pending entries are discarded. The cycle after deassertion behaves identically to post-reset.

Decomposition:
- Shared package imm_pkg holds:
  - the IMM_* selector localparams (IMM_NONE..IMM_ZIMM = 3'd0..3'd7);
  - the opcode localparams used by control to derive in_sel.
- Sub-module imm_gen_core: purely combinational (inst, sel) -> imm, parametrised by DATA_LENGTH. It is reusable by the execute-stage branch unit.
- The top level holds the skid/handshake logic only.

Test Plan:
1. I, S and J formats, DATA_LENGTH=32, out_ready=1:
   - inst 0xFFF00093, sel=001 -> out_imm=0xFFFFFFFF one cycle later.
   - inst 0xFE112E23, sel=011 -> 0xFFFFFFFC.
   - inst 0xFFDFF06F, sel=101 -> 0xFFFFFFFC.
2. B and U formats at both widths:
   - inst 0x00000863, sel=010 -> 0x00000010.
   - inst 0x123450B7, sel=100 -> 0x12345000.
   - DATA_LENGTH=64, inst 0x800000B7, sel=100 -> 0xFFFFFFFF80000000.
3. SHAMT and ZIMM:
   - DATA_LENGTH=64, inst 0x03F09093 (slli x1,x1,63), sel=110 -> 0x3F.
   - inst 0x3400D073 (csrrwi, zimm=1), sel=111 -> 0x1.
4. Backpressure:
   - Stream tags 1..6 with in_valid held at 1; out_ready=0 for cycles 2-4.
   - Required: in_ready=0 after two accepts; output holds tag 1 stable.
   - Tags 1..6 emerge in order with no gaps once out_ready=1; throughput returns to 1 per cycle.
5. Flush with both entries full and in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed input never appears at the output.
6. Reset mid-stream:
   - Assert rst for 1 cycle with main and skid valid -> out_valid=0, out_imm=0, out_tag=0.
   - The next accepted input appears after exactly 1 cycle.
